ldm_sequencer: RTL

Decode-stage micro-sequencer that expands ARM block-transfer instructions (LDM/STM, all four addressing modes) into single-register LDR/STR micro-ops, plus an optional base-writeback ADD/SUB. Each micro-op is presented to the main decoder and extender as an ordinary instruction:
- Transfers use the 12-bit unsigned immediate path.
- Writeback uses the 8-bit immediate path.

While expanding, it stalls fetch and holds the decode register through the hazard unit. All other instructions pass through unchanged.

---
 rtl/ldm_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ldm_sequencer.sv
// ============================================================================
// ldm_sequencer : expands LDM/STM into single-register LDR/STR micro-ops plus
//                 an optional base-writeback ADD/SUB; other instructions pass.
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module ldm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] UopInstr,
  output logic        UopValid,
  output logic        BusyD,
  output logic        UopLast
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [4:0]  k_q, k_d;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, v[i]};
    return cnt;
  endfunction

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = i[3:0];
    return idx;
  endfunction

  logic              is_block;
  logic [3:0]        cond, rn, rd;
  logic              p_bit, u_bit, w_bit, l_bit;
  logic [15:0]       list, cur_mask, rest_mask;
  logic [4:0]        n, cur_k;
  logic              wb_pending;
  logic signed [8:0] base4k, n4, offset, mag;
  logic [31:0]       xfer_word, wb_word;

  assign is_block   = ValidD && (InstrD[27:25] == 3'b100);
  assign cond       = InstrD[31:28];
  assign p_bit      = InstrD[24];
  assign u_bit      = InstrD[23];
  assign w_bit      = InstrD[21];
  assign l_bit      = InstrD[20];
  assign rn         = InstrD[19:16];
  assign list       = InstrD[15:0];
  assign n          = popcount16(list);
  // A load that overwrites the base makes the writeback meaningless.
  assign wb_pending = w_bit && (n != 5'd0) && !(l_bit && list[rn]);

  // The decode register is held while busy, so InstrD stays valid for all ops.
  assign cur_mask  = (state_q == S_IDLE) ? list : mask_q;
  assign cur_k     = (state_q == S_IDLE) ? 5'd0 : k_q;
  assign rd        = lowest_idx(cur_mask);
  assign rest_mask = cur_mask & ~(16'd1 << rd);

  assign base4k = $signed({2'b00, cur_k, 2'b00});
  assign n4     = $signed({2'b00, n, 2'b00});

  always_comb begin
    offset = base4k;
    case ({p_bit, u_bit})
      2'b01:   offset = base4k;
      2'b11:   offset = base4k + 9'sd4;
      2'b00:   offset = base4k - n4 + 9'sd4;
      default: offset = base4k - n4;
    endcase
  end

  assign mag       = offset[8] ? -offset : offset;
  assign xfer_word = {cond, 2'b01, 1'b0, 1'b1, !offset[8], 1'b0, 1'b0, l_bit,
                      rn, rd, 4'h0, mag[7:0]};
  assign wb_word   = {cond, (u_bit ? 8'h28 : 8'h24), rn, rn, 4'h0, 1'b0, n, 2'b00};

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    k_d      = k_q;
    UopInstr = InstrD;
    UopValid = 1'b0;
    BusyD    = 1'b0;
    UopLast  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!is_block) begin
          UopValid = ValidD;
          UopLast  = 1'b1;
        end else if (n != 5'd0) begin
          UopInstr = xfer_word;
          UopValid = 1'b1;
          if ((rest_mask != 16'd0) || wb_pending) begin
            BusyD   = 1'b1;
            mask_d  = rest_mask;
            k_d     = 5'd1;
            state_d = (rest_mask != 16'd0) ? S_XFER : S_WB;
          end else begin
            UopLast = 1'b1;
          end
        end
      end
      S_XFER: begin
        UopInstr = xfer_word;
        UopValid = 1'b1;
        mask_d   = rest_mask;
        k_d      = k_q + 5'd1;
        if (rest_mask != 16'd0) begin
          BusyD = 1'b1;
        end else if (wb_pending) begin
          BusyD   = 1'b1;
          state_d = S_WB;
        end else begin
          UopLast = 1'b1;
          state_d = S_IDLE;
          k_d     = 5'd0;
        end
      end
      S_WB: begin
        UopInstr = wb_word;
        UopValid = 1'b1;
        UopLast  = 1'b1;
        state_d  = S_IDLE;
        mask_d   = 16'd0;
        k_d      = 5'd0;
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = 16'd0;
        k_d     = 5'd0;
      end
    endcase

    if (StallD) begin
      state_d = state_q;
      mask_d  = mask_q;
      k_d     = k_q;
    end

    if (FlushD) begin
      UopValid = 1'b0;
      BusyD    = 1'b0;
      UopLast  = 1'b0;
      state_d  = S_IDLE;
      mask_d   = 16'd0;
      k_d      = 5'd0;
    end

    if (reset) begin
      UopValid = 1'b0;
      BusyD    = 1'b0;
      UopLast  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= 16'd0;
      k_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
    end
  end

endmodule

`default_nettype wire
